// File: rtl/logic_unit_pkg.sv
// Shared types and widths for the pipelined bitwise logic unit.
package logic_unit_pkg;
  localparam int LU_OP_W = 3;
  localparam int STAT_W  = 16;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND  = 3'd0,
    LU_OR   = 3'd1,
    LU_XOR  = 3'd2,
    LU_NAND = 3'd3,
    LU_NOR  = 3'd4,
    LU_XNOR = 3'd5,
    LU_NOT  = 3'd6,
    LU_PASS = 3'd7
  } lu_op_e;
endpackage

// File: rtl/lu_stage.sv
// Generic valid/ready register slice: holds one payload, refills in the same
// cycle its current content leaves.
module lu_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_reg;
  logic [W-1:0] payload_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = payload_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      payload_reg <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) payload_reg <= in_data;
    end
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with zero/parity flags.
// Optional transfer counter enabled by defining LOGIC_UNIT_STATS_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic [LU_OP_W-1:0] out_op,
  output logic               out_zero,
  output logic               out_parity
`ifdef LOGIC_UNIT_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [STAT_W-1:0]  stat_count
`endif
);
  localparam int S1_W = 2 * WIDTH + LU_OP_W;
  localparam int S2_W = WIDTH + LU_OP_W + 2;

  logic            s1_valid;
  logic            s2_ready;
  logic [S1_W-1:0] s1_data;
  logic [S2_W-1:0] s2_in;
  logic [S2_W-1:0] s2_data;

  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [LU_OP_W-1:0] s1_op;
  logic [WIDTH-1:0]   y_calc;

  lu_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, in_b, in_a}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_a  = s1_data[WIDTH-1:0];
  assign s1_b  = s1_data[2*WIDTH-1:WIDTH];
  assign s1_op = s1_data[S1_W-1:2*WIDTH];

  always_comb begin
    y_calc = '0;
    case (lu_op_e'(s1_op))
      LU_AND:  y_calc = s1_a & s1_b;
      LU_OR:   y_calc = s1_a | s1_b;
      LU_XOR:  y_calc = s1_a ^ s1_b;
      LU_NAND: y_calc = ~(s1_a & s1_b);
      LU_NOR:  y_calc = ~(s1_a | s1_b);
      LU_XNOR: y_calc = ~(s1_a ^ s1_b);
      LU_NOT:  y_calc = ~s1_a;
      LU_PASS: y_calc = s1_a;
      default: y_calc = '0;
    endcase
  end

  // Flags travel in the same slice as the result so they never disagree with out_y.
  assign s2_in = {^y_calc, ~|y_calc, s1_op, y_calc};

  lu_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_y      = s2_data[WIDTH-1:0];
  assign out_op     = s2_data[WIDTH+LU_OP_W-1:WIDTH];
  assign out_zero   = s2_data[WIDTH+LU_OP_W];
  assign out_parity = s2_data[WIDTH+LU_OP_W+1];

`ifdef LOGIC_UNIT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count <= '0;
    end else if (stat_clr) begin
      stat_count <= '0;
    end else if (out_valid && out_ready && (stat_count != {STAT_W{1'b1}})) begin
      stat_count <= stat_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe at WIDTH 8, 1 and 64.
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, out_ready;
  logic [63:0] a64, b64;
  logic [2:0]  op;

  logic       r8, v8, z8, p8;
  logic [7:0] y8;
  logic [2:0] o8;
  logic       r1, v1, z1, p1;
  logic [0:0] y1;
  logic [2:0] o1;
  logic        r64, v64, z64, p64;
  logic [63:0] y64;
  logic [2:0]  o64;

`ifdef LOGIC_UNIT_STATS_EN
  logic        stat_clr;
  logic [15:0] sc8, sc1, sc64;
`endif

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8),
    .in_a(a64[7:0]), .in_b(b64[7:0]), .in_op(op),
    .out_valid(v8), .out_ready(out_ready), .out_y(y8), .out_op(o8),
    .out_zero(z8), .out_parity(p8)
`ifdef LOGIC_UNIT_STATS_EN
    , .stat_clr(stat_clr), .stat_count(sc8)
`endif
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
    .in_a(a64[0:0]), .in_b(b64[0:0]), .in_op(op),
    .out_valid(v1), .out_ready(out_ready), .out_y(y1), .out_op(o1),
    .out_zero(z1), .out_parity(p1)
`ifdef LOGIC_UNIT_STATS_EN
    , .stat_clr(stat_clr), .stat_count(sc1)
`endif
  );

  logic_unit_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64),
    .in_a(a64), .in_b(b64), .in_op(op),
    .out_valid(v64), .out_ready(out_ready), .out_y(y64), .out_op(o64),
    .out_zero(z64), .out_parity(p64)
`ifdef LOGIC_UNIT_STATS_EN
    , .stat_clr(stat_clr), .stat_count(sc64)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the op table applied to full 64-bit words, then cut to width.
  function automatic logic [63:0] ref_y(input logic [2:0] o, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
    logic [63:0] r, mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = ~a;
      default: r = a;
    endcase
    return r & mask;
  endfunction

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, y;
    logic       z, p;
  } vec_t;
  vec_t tbl[10];

  typedef struct {
    logic [63:0] y;
    logic [2:0]  op;
  } exp_t;
  exp_t sbq[3][$];

  task automatic drive(input logic v, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    in_valid = v; op = o; a64 = a; b64 = b;
  endtask

  task automatic sb_check(input int idx, input string tag, input logic v, input logic rdy,
                          input logic [63:0] y, input logic [2:0] o, input logic z, input logic p);
    exp_t e;
    if (v && rdy) begin
      if (sbq[idx].size() == 0) begin
        check({tag, "_unexpected_beat"}, 64'd1, 64'd0);
      end else begin
        e = sbq[idx].pop_front();
        check({tag, "_y"}, y, e.y);
        check({tag, "_op"}, {61'd0, o}, {61'd0, e.op});
        check({tag, "_zero"}, {63'd0, z}, {63'd0, (e.y == 64'd0)});
        check({tag, "_parity"}, {63'd0, p}, {63'd0, ^e.y});
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  held_y, bp_a;
    logic [2:0]  held_o;
    logic        held_z, held_p, prev_stall;
    logic [63:0] prev_y;
    logic [7:0]  bp_exp[5];
    int j, n_out, first_c, last_c;

`ifdef LOGIC_UNIT_STATS_EN
    stat_clr = 1'b0;
`endif
    do_reset();
    check("reset_out_valid", {63'd0, v8}, 64'd0);
    check("reset_out_y", {56'd0, y8}, 64'd0);
    check("reset_out_op", {61'd0, o8}, 64'd0);
    check("reset_out_zero", {63'd0, z8}, 64'd0);
    check("reset_out_parity", {63'd0, p8}, 64'd0);
    check("reset_in_ready", {63'd0, r8}, 64'd1);

    tbl[0] = '{3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0};
    tbl[1] = '{3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0};
    tbl[3] = '{3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0};
    tbl[4] = '{3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0};
    tbl[6] = '{3'd6, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0};
    tbl[7] = '{3'd7, 8'hA5, 8'h0F, 8'hA5, 1'b0, 1'b0};
    tbl[8] = '{3'd0, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
    tbl[9] = '{3'd2, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1};

    // Back-to-back table: beat i must show exactly two edges after acceptance.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (i < 10) drive(1'b1, tbl[i].op, {56'd0, tbl[i].a}, {56'd0, tbl[i].b});
      else        drive(1'b0, 3'd0, 64'd0, 64'd0);
      @(negedge clk);
      if (i < 10) check("sweep_in_ready", {63'd0, r8}, 64'd1);
      if (i >= 2) begin
        check("sweep_out_valid", {63'd0, v8}, 64'd1);
        check("sweep_y", {56'd0, y8}, {56'd0, tbl[i-2].y});
        check("sweep_op", {61'd0, o8}, {61'd0, tbl[i-2].op});
        check("sweep_zero", {63'd0, z8}, {63'd0, tbl[i-2].z});
        check("sweep_parity", {63'd0, p8}, {63'd0, tbl[i-2].p});
      end else begin
        check("sweep_latency_valid", {63'd0, v8}, 64'd0);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("sweep_no_extra", {63'd0, v8}, 64'd0);

    // Backpressure: five beats into a stalled pipe.
    for (int k = 0; k < 5; k++) begin
      bp_a = 8'h3C + 8'(k * 17);
      bp_exp[k] = ref_y(3'(k), {56'd0, bp_a}, 64'h5A, 8)[7:0];
    end
    j = 0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(1'b1, 3'(j), {56'd0, 8'h3C + 8'(j * 17)}, 64'h5A);
      @(negedge clk);
      check("bp_in_ready_attempt", {63'd0, r8}, (t < 2) ? 64'd1 : 64'd0);
      if (r8) j++;
    end
    held_y = y8; held_o = o8; held_z = z8; held_p = p8;
    check("bp_held_first", {56'd0, y8}, {56'd0, bp_exp[0]});
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_hold_valid", {63'd0, v8}, 64'd1);
      check("bp_hold_in_ready", {63'd0, r8}, 64'd0);
      check("bp_hold_y", {56'd0, y8}, {56'd0, held_y});
      check("bp_hold_flags", {60'd0, o8, z8 ^ held_z ^ p8 ^ held_p}, {60'd0, held_o, 1'b0});
    end
    n_out = 0; first_c = -1; last_c = -1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (j < 5) drive(1'b1, 3'(j), {56'd0, 8'h3C + 8'(j * 17)}, 64'h5A);
      else       drive(1'b0, 3'd0, 64'd0, 64'd0);
      @(negedge clk);
      if (v8) begin
        if (n_out < 5) check("bp_drain_y", {56'd0, y8}, {56'd0, bp_exp[n_out]});
        if (first_c < 0) first_c = t;
        last_c = t;
        n_out++;
      end
      if (in_valid && r8) j++;
    end
    check("bp_drain_count", 64'(n_out), 64'd5);
    check("bp_drain_rate", 64'(last_c - first_c), 64'd4);

    // Reset with two beats in flight.
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(1'b1, 3'd7, 64'hFF, 64'd0);
    end
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    @(negedge clk);
    check("rst_pre_valid", {63'd0, v8}, 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {63'd0, v8}, 64'd0);
    check("rst_async_y", {56'd0, y8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, r8}, 64'd1);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_no_stale", {63'd0, v8}, 64'd0);
    end

    // Random stall traffic against per-width scoreboards.
    do_reset();
    prev_stall = 1'b0; prev_y = '0;
    for (int c = 0; c < 1010; c++) begin
      @(posedge clk); #1;
      if (c < 1000) begin
        drive(($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)),
              {$urandom, $urandom}, {$urandom, $urandom});
        out_ready = ($urandom_range(0, 99) < 60);
      end else begin
        drive(1'b0, 3'd0, 64'd0, 64'd0);
        out_ready = 1'b1;
      end
      @(negedge clk);
      sb_check(0, "rnd_w8", v8, out_ready, {56'd0, y8}, o8, z8, p8);
      sb_check(1, "rnd_w1", v1, out_ready, {63'd0, y1}, o1, z1, p1);
      sb_check(2, "rnd_w64", v64, out_ready, y64, o64, z64, p64);
      if (prev_stall) check("rnd_w8_stall_hold", {56'd0, y8}, prev_y);
      prev_stall = v8 && !out_ready;
      prev_y = {56'd0, y8};
      if (in_valid && r8)  sbq[0].push_back('{ref_y(op, a64, b64, 8), op});
      if (in_valid && r1)  sbq[1].push_back('{ref_y(op, a64, b64, 1), op});
      if (in_valid && r64) sbq[2].push_back('{ref_y(op, a64, b64, 64), op});
    end
    check("rnd_w8_drained", 64'(sbq[0].size()), 64'd0);
    check("rnd_w1_drained", 64'(sbq[1].size()), 64'd0);
    check("rnd_w64_drained", 64'(sbq[2].size()), 64'd0);

`ifdef LOGIC_UNIT_STATS_EN
    do_reset();
    check("stat_reset", {48'd0, sc8}, 64'd0);
    @(posedge clk); #1;
    drive(1'b1, 3'd1, 64'h3, 64'h4);
    out_ready = 1'b1;
    repeat (70010) @(posedge clk);
    @(negedge clk);
    check("stat_saturated", {48'd0, sc8}, 64'hFFFF);
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(negedge clk);
    check("stat_clr_with_transfer", {63'd0, v8 & out_ready}, 64'd1);
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    check("stat_cleared", {48'd0, sc8}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stat_recount", {48'd0, sc8}, 64'd1);
    drive(1'b0, 3'd0, 64'd0, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
